// File: rtl/mult_cdb_buffer_pkg.sv
// Shared types and constants for the multiplier completion buffer.
package mult_cdb_buffer_pkg;

  localparam int DATA_W         = 64;
  localparam int NUM_PHYS_REGS  = 64;
  localparam int PHYS_REG_W     = $clog2(NUM_PHYS_REGS);
  localparam int MULT_BUF_DEPTH = 4;

  typedef logic [DATA_W-1:0]     DATA;
  typedef logic [PHYS_REG_W-1:0] PHYS_REG;

  // One completed product waiting for the common data bus.
  typedef struct packed {
    DATA     value;
    PHYS_REG tag;
  } CDB_ENTRY;

endpackage

// File: rtl/mult_cdb_fifo.sv
// Generic DEPTH-entry FIFO of CDB entries with registered count.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module mult_cdb_fifo
  import mult_cdb_buffer_pkg::*;
#(
  parameter int DEPTH = MULT_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  CDB_ENTRY         i_data,
  output CDB_ENTRY         o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  CDB_ENTRY         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_doPop;
  logic w_doPush;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_tail <= r_tail + PTR_W'(1);
      if (w_doPop)  r_head <= r_head + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/mult_cdb_buffer.sv
// Completion buffer between the pipelined multiplier and the CDB arbiter.
// Holds finished products in a FIFO and hands out issue credits so the
// non-stallable multiplier always finds a free slot.
module mult_cdb_buffer
  import mult_cdb_buffer_pkg::*;
#(
  parameter int DEPTH = MULT_BUF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    fus_en,
  input  logic    mult_done,
  input  DATA     mult_result,
  input  PHYS_REG mult_tagDest,
  input  logic    cdb_grant,
  output logic    cdb_req,
  output DATA     cdb_value,
  output PHYS_REG cdb_tag,
  output logic    mult_ready,
  output logic    buf_overflow
);

  logic [CNT_W-1:0] r_credits;
  logic             r_overflow;

  CDB_ENTRY         w_pushData;
  CDB_ENTRY         w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_issueOk;
  logic             w_issueBad;
  logic             w_pushDrop;

  assign w_pushData.value = mult_result;
  assign w_pushData.tag   = mult_tagDest;

  // A grant only retires something when an entry is actually being presented.
  assign w_pop      = cdb_grant && !w_empty;
  assign w_issueOk  = fus_en && (r_credits != '0);
  assign w_issueBad = fus_en && (r_credits == '0);
  assign w_pushDrop = mult_done && w_full && !w_pop;

  mult_cdb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (mult_done),
    .i_pop   (w_pop),
    .i_data  (w_pushData),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Credit counter: issue takes one, retirement returns one, saturating at both ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= CNT_W'(DEPTH);
    end else begin
      case ({w_issueOk, w_pop})
        2'b10: r_credits <= r_credits - CNT_W'(1);
        2'b01: begin
          if (r_credits != CNT_W'(DEPTH)) r_credits <= r_credits + CNT_W'(1);
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Sticky error flag for issuing without credit or losing a product to a full buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_issueBad || w_pushDrop) begin
      r_overflow <= 1'b1;
    end
  end

  assign cdb_req      = (w_count != '0);
  assign cdb_value    = w_head.value;
  assign cdb_tag      = w_head.tag;
  assign mult_ready   = (r_credits != '0);
  assign buf_overflow = r_overflow;

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Directed and randomized checks for the multiplier completion buffer.
module tb_mult_cdb_buffer;
  import mult_cdb_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic    clk = 1'b0;
  logic    reset;
  logic    fus_en;
  logic    mult_done;
  DATA     mult_result;
  PHYS_REG mult_tagDest;
  logic    cdb_grant;
  logic    cdb_req;
  DATA     cdb_value;
  PHYS_REG cdb_tag;
  logic    mult_ready;
  logic    buf_overflow;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mult_cdb_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fus_en       (fus_en),
    .mult_done    (mult_done),
    .mult_result  (mult_result),
    .mult_tagDest (mult_tagDest),
    .cdb_grant    (cdb_grant),
    .cdb_req      (cdb_req),
    .cdb_value    (cdb_value),
    .cdb_tag      (cdb_tag),
    .mult_ready   (mult_ready),
    .buf_overflow (buf_overflow)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then waits until just after the clock edge.
  task automatic applyStimulus(input logic issue, input logic done, input DATA result,
                               input PHYS_REG tag, input logic grant);
    fus_en       = issue;
    mult_done    = done;
    mult_result  = result;
    mult_tagDest = tag;
    cdb_grant    = grant;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Directed sequence followed by a randomized soak against a latency-4 multiplier model.
  initial begin
    DATA      fillVals [4];
    PHYS_REG  expTags  [4];
    DATA      expVals  [4];
    logic     pV [4];
    DATA      pR [4];
    PHYS_REG  pT [4];
    CDB_ENTRY expQ [$];
    CDB_ENTRY expEntry;
    int       modelCredits;
    int       modelCount;
    logic     grant;
    logic     issue;
    logic     popNow;
    logic     doneNow;
    DATA      opA;
    DATA      opB;
    PHYS_REG  nextTag;

    fillVals = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF9C,
                 64'h0, 64'h1};

    reset        = 1'b1;
    fus_en       = 1'b0;
    mult_done    = 1'b0;
    mult_result  = '0;
    mult_tagDest = '0;
    cdb_grant    = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    checkOutput("reset_req",      64'(cdb_req),      64'd0);
    checkOutput("reset_ready",    64'(mult_ready),   64'd1);
    checkOutput("reset_overflow", 64'(buf_overflow), 64'd0);

    // Single operation: issue, result one cycle later visible, grant retires it.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("single_ready_after_issue", 64'(mult_ready), 64'd1);
    checkOutput("single_req_before_done",   64'(cdb_req),    64'd0);
    applyStimulus(1'b0, 1'b1, 64'h6, PHYS_REG'(5), 1'b0);
    checkOutput("single_req",   64'(cdb_req),   64'd1);
    checkOutput("single_value", cdb_value,      64'h6);
    checkOutput("single_tag",   64'(cdb_tag),   64'd5);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("single_req_after_grant", 64'(cdb_req),    64'd0);
    checkOutput("single_ready_after",     64'(mult_ready), 64'd1);

    // Fill: four issues exhaust credits, four back-to-back results fill the FIFO.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("fill_ready_zero", 64'(mult_ready), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, fillVals[i], PHYS_REG'(i + 1), 1'b0);
    checkOutput("fill_req",        64'(cdb_req),      64'd1);
    checkOutput("fill_head_tag",   64'(cdb_tag),      64'd1);
    checkOutput("fill_head_value", cdb_value,         64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("fill_overflow",   64'(buf_overflow), 64'd0);
    checkOutput("fill_ready_held", 64'(mult_ready),   64'd0);

    // Full buffer: push and grant together keep it full and append at the tail.
    applyStimulus(1'b0, 1'b1, 64'h55, PHYS_REG'(9), 1'b1);
    checkOutput("simul_overflow", 64'(buf_overflow), 64'd0);
    checkOutput("simul_ready",    64'(mult_ready),   64'd1);
    expTags = '{PHYS_REG'(2), PHYS_REG'(3), PHYS_REG'(4), PHYS_REG'(9)};
    expVals = '{64'hFFFF_FFFF_FFFF_FF9C, 64'h0, 64'h1, 64'h55};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_req_%0d", i),   64'(cdb_req), 64'd1);
      checkOutput($sformatf("drain_tag_%0d", i),   64'(cdb_tag), 64'(expTags[i]));
      checkOutput($sformatf("drain_value_%0d", i), cdb_value,    expVals[i]);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    end
    checkOutput("drain_empty", 64'(cdb_req), 64'd0);

    // Reset in the middle of a stream with three entries queued.
    pulseReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 64'(i), PHYS_REG'(20 + i), 1'b0);
    checkOutput("mid_req_queued", 64'(cdb_req), 64'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("mid_reset_req",      64'(cdb_req),      64'd0);
    checkOutput("mid_reset_ready",    64'(mult_ready),   64'd1);
    checkOutput("mid_reset_overflow", 64'(buf_overflow), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    // Push while full with no grant: fifth entry dropped, flag set.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 64'(100 + i), PHYS_REG'(10 + i), 1'b0);
    checkOutput("drop_overflow", 64'(buf_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drop_tag_%0d", i), 64'(cdb_tag), 64'(10 + i));
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    end
    checkOutput("drop_empty", 64'(cdb_req), 64'd0);
    pulseReset();

    // Issue with zero credits sets the flag and leaves credits at zero.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("viol_no_flag_yet", 64'(buf_overflow), 64'd0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("viol_overflow", 64'(buf_overflow), 64'd1);
    checkOutput("viol_ready",    64'(mult_ready),   64'd0);
    applyStimulus(1'b0, 1'b1, 64'h7, PHYS_REG'(7), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("viol_one_credit_back", 64'(mult_ready),   64'd1);
    checkOutput("viol_flag_sticky",     64'(buf_overflow), 64'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("viol_reset_clears", 64'(buf_overflow), 64'd0);
    checkOutput("viol_reset_ready",  64'(mult_ready),   64'd1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    // Randomized soak with a fixed-latency multiplier model.
    for (int s = 0; s < 4; s++) begin
      pV[s] = 1'b0;
      pR[s] = '0;
      pT[s] = '0;
    end
    modelCredits = DEPTH;
    modelCount   = 0;
    nextTag      = '0;
    for (int cyc = 0; cyc < 430; cyc++) begin
      checkOutput("soak_req",   64'(cdb_req),    64'(modelCount != 0));
      checkOutput("soak_ready", 64'(mult_ready), 64'(modelCredits != 0));
      grant  = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      popNow = grant && (modelCount != 0);
      if (popNow) begin
        if (expQ.size() == 0) begin
          checkOutput("soak_queue_underrun", 64'd1, 64'd0);
        end else begin
          expEntry = expQ.pop_front();
          checkOutput("soak_value", cdb_value,    expEntry.value);
          checkOutput("soak_tag",   64'(cdb_tag), 64'(expEntry.tag));
        end
      end
      issue = (cyc < 400) && (modelCredits != 0) && ($urandom_range(0, 1) != 0);
      opA = {$urandom, $urandom};
      opB = {$urandom, $urandom};
      doneNow = pV[3];
      applyStimulus(issue, doneNow, pR[3], pT[3], grant);
      modelCredits = modelCredits - int'(issue) + int'(popNow);
      modelCount   = modelCount + int'(doneNow) - int'(popNow);
      for (int s = 3; s > 0; s--) begin
        pV[s] = pV[s-1];
        pR[s] = pR[s-1];
        pT[s] = pT[s-1];
      end
      pV[0] = issue;
      pR[0] = opA * opB;
      pT[0] = nextTag;
      if (issue) begin
        expQ.push_back('{value: opA * opB, tag: nextTag});
        nextTag = nextTag + PHYS_REG'(1);
      end
    end
    checkOutput("soak_all_retired", 64'(expQ.size()),  64'd0);
    checkOutput("soak_final_req",   64'(cdb_req),      64'd0);
    checkOutput("soak_overflow",    64'(buf_overflow), 64'd0);

    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
